// File: rtl/fp_class_pkg.sv
// Shared constants and types for the FP classification stream.
// Class bit indices, one-hot class width and class type.
package fp_class_pkg;

  localparam int CLS_W    = 6;
  localparam int CLS_ZERO = 0;
  localparam int CLS_SUB  = 1;
  localparam int CLS_NORM = 2;
  localparam int CLS_INF  = 3;
  localparam int CLS_QNAN = 4;
  localparam int CLS_SNAN = 5;

  typedef logic [CLS_W-1:0] cls_t;

endpackage

// File: rtl/fp_class_lane.sv
// Classifies one FP operand into a one-hot class and its sign.
// Combinational; one instance per lane.
module fp_class_lane
  import fp_class_pkg::*;
#(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0] ind,
  output cls_t                            cls,
  output logic                            sign
);

  logic [SIGN_W-1:0] f_sign;
  logic [EXPO_W-1:0] f_expo;
  logic [MANT_W-1:0] f_mant;
  logic exp_zero;
  logic exp_ones;
  logic man_zero;
  logic man_msb;

  fp_unpack #(
    .SIGN_W(SIGN_W),
    .EXPO_W(EXPO_W),
    .MANT_W(MANT_W)
  ) u_unpack (
    .ind (ind),
    .sign(f_sign),
    .expo(f_expo),
    .mant(f_mant)
  );

  assign sign     = f_sign[SIGN_W-1];
  assign exp_zero = (f_expo == '0);
  assign exp_ones = &f_expo;
  assign man_zero = (f_mant == '0);
  assign man_msb  = f_mant[MANT_W-1];

  // Mutually exclusive decode of exponent/mantissa patterns
  always_comb begin
    cls = '0;
    unique case (1'b1)
      exp_zero && man_zero:
        cls[CLS_ZERO] = 1'b1;
      exp_zero && !man_zero:
        cls[CLS_SUB] = 1'b1;
      !exp_zero && !exp_ones:
        cls[CLS_NORM] = 1'b1;
      exp_ones && man_zero:
        cls[CLS_INF] = 1'b1;
      exp_ones && man_msb:
        cls[CLS_QNAN] = 1'b1;
      exp_ones && !man_msb && !man_zero:
        cls[CLS_SNAN] = 1'b1;
      default:
        cls = '0;
    endcase
  end

endmodule

// File: rtl/fp_unpack.sv
// Splits a packed FP word into sign, exponent and mantissa fields.
// Purely combinational field extraction.
module fp_unpack #(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0] ind,
  output logic [SIGN_W-1:0]               sign,
  output logic [EXPO_W-1:0]               expo,
  output logic [MANT_W-1:0]               mant
);

  assign {sign, expo, mant} = ind;

endmodule

// File: rtl/fp_class_stream.sv
// Two-stage valid/ready FP classifier with zero count and NaN flag.
// S1 holds raw operands, S2 holds class and sign per lane.
module fp_class_stream #(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*(SIGN_W+EXPO_W+MANT_W)-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*6-1:0]               out_class,
  output logic [LANES-1:0]                 out_sign,
  input  logic                             cnt_clr,
  output logic [CNT_W-1:0]                 zero_cnt,
  output logic                             nan_sticky
);

  import fp_class_pkg::*;

  localparam int FP_W  = SIGN_W + EXPO_W + MANT_W;
  localparam int ZC_W  = $clog2(LANES + 1);
  localparam int SUM_W = ((CNT_W > ZC_W) ? CNT_W : ZC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX =
    (SUM_W'(1) << CNT_W) - SUM_W'(1);

  logic                      s1_valid_q, s1_valid_d;
  logic [LANES*FP_W-1:0]     s1_data_q, s1_data_d;
  logic                      s2_valid_q, s2_valid_d;
  logic [LANES*CLS_W-1:0]    cls_q, cls_d;
  logic [LANES-1:0]          sign_q, sign_d;
  logic [CNT_W-1:0]          zero_cnt_q, zero_cnt_d;
  logic                      nan_q, nan_d;

  logic                      s2_en;
  logic                      in_fire;
  logic                      out_fire;
  logic [LANES*CLS_W-1:0]    lane_cls;
  logic [LANES-1:0]          lane_sign;
  logic [LANES-1:0]          zero_vec;
  logic [LANES-1:0]          nan_vec;
  logic [ZC_W-1:0]           zero_pop;
  logic [SUM_W-1:0]          cnt_base;
  logic [SUM_W-1:0]          cnt_sum;
  logic [CNT_W-1:0]          cnt_sat;

  // Balanced pairwise tree over a heap layout; works for any LANES
  function automatic logic [ZC_W-1:0] pop_tree(
    input logic [LANES-1:0] v
  );
    logic [ZC_W-1:0] node [1:2*LANES-1];
    for (int i = 0; i < LANES; i++)
      node[LANES+i] = ZC_W'(v[i]);
    for (int i = LANES - 1; i >= 1; i--)
      node[i] = node[2*i] + node[2*i+1];
    return node[1];
  endfunction

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp_class_lane #(
      .SIGN_W(SIGN_W),
      .EXPO_W(EXPO_W),
      .MANT_W(MANT_W)
    ) u_lane (
      .ind (s1_data_q[g*FP_W +: FP_W]),
      .cls (lane_cls[g*CLS_W +: CLS_W]),
      .sign(lane_sign[g])
    );
    assign zero_vec[g] = cls_q[g*CLS_W + CLS_ZERO];
    assign nan_vec[g]  = cls_q[g*CLS_W + CLS_QNAN]
                       | cls_q[g*CLS_W + CLS_SNAN];
  end

  assign s2_en    = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_en;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;
  assign zero_pop = pop_tree(zero_vec);

  // Next state for both pipeline stages
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    cls_d      = cls_q;
    sign_d     = sign_q;
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      s1_valid_d = 1'b0;
      if (s1_valid_q) begin
        cls_d  = lane_cls;
        sign_d = lane_sign;
      end
    end
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
    end
  end

  // Statistics: clear restarts from the concurrent beat
  always_comb begin
    cnt_base = cnt_clr ? '0 : SUM_W'(zero_cnt_q);
    cnt_sum  = cnt_base + SUM_W'(zero_pop);
    cnt_sat  = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0]
                                   : cnt_sum[CNT_W-1:0];
    zero_cnt_d = cnt_clr ? '0 : zero_cnt_q;
    if (out_fire)
      zero_cnt_d = cnt_sat;
    nan_d = (out_fire && (|nan_vec)) || (nan_q && !cnt_clr);
  end

  // Control, class outputs and statistics with reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      cls_q      <= '0;
      sign_q     <= '0;
      zero_cnt_q <= '0;
      nan_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      cls_q      <= cls_d;
      sign_q     <= sign_d;
      zero_cnt_q <= zero_cnt_d;
      nan_q      <= nan_d;
    end
  end

  // Operand holding register, no reset needed
  always_ff @(posedge clk) begin
    s1_data_q <= s1_data_d;
  end

  assign out_valid  = s2_valid_q;
  assign out_class  = cls_q;
  assign out_sign   = sign_q;
  assign zero_cnt   = zero_cnt_q;
  assign nan_sticky = nan_q;

endmodule

// File: tb/tb_fp_class_stream.sv
// Directed testbench for fp_class_stream.
// Default instance plus a CNT_W=4 instance for saturation.
module tb_fp_class_stream;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [23:0]  out_class;
  logic [3:0]   out_sign;
  logic         cnt_clr;
  logic [15:0]  zero_cnt;
  logic         nan_sticky;

  logic         in_valid_4;
  logic         in_ready_4;
  logic [127:0] in_data_4;
  logic         out_valid_4;
  logic         out_ready_4;
  logic [23:0]  out_class_4;
  logic [3:0]   out_sign_4;
  logic         cnt_clr_4;
  logic [3:0]   zero_cnt_4;
  logic         nan_sticky_4;

  int checks;
  int errors;

  fp_class_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_sign  (out_sign),
    .cnt_clr   (cnt_clr),
    .zero_cnt  (zero_cnt),
    .nan_sticky(nan_sticky)
  );

  fp_class_stream #(.CNT_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_4),
    .in_ready  (in_ready_4),
    .in_data   (in_data_4),
    .out_valid (out_valid_4),
    .out_ready (out_ready_4),
    .out_class (out_class_4),
    .out_sign  (out_sign_4),
    .cnt_clr   (cnt_clr_4),
    .zero_cnt  (zero_cnt_4),
    .nan_sticky(nan_sticky_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
    checks++;
    if (out_class !== 24'h0 || out_sign !== 4'h0) begin
      errors++;
      $display("FAIL reset_out_data got %h/%h exp 0/0",
               out_class, out_sign);
    end
    checks++;
    if (zero_cnt !== 16'd0 || nan_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_stats got %0d/%b exp 0/0",
               zero_cnt, nan_sticky);
    end
  endtask

  task automatic test_classes();
    in_valid = 1'b1;
    in_data  = {32'h3F800000, 32'h00000001,
                32'h80000000, 32'h00000000};
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL cls_latency1 got %b exp 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL cls_latency2 got %b exp 1", out_valid);
    end
    checks++;
    if (out_class !== {6'h04, 6'h02, 6'h01, 6'h01}) begin
      errors++;
      $display("FAIL cls_class got %h exp %h", out_class,
               {6'h04, 6'h02, 6'h01, 6'h01});
    end
    checks++;
    if (out_sign !== 4'b0010) begin
      errors++;
      $display("FAIL cls_sign got %b exp 0010", out_sign);
    end
    tick();
    checks++;
    if (zero_cnt !== 16'd2 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL cls_zero_cnt got %0d/%b exp 2/0",
               zero_cnt, out_valid);
    end
  endtask

  task automatic test_special();
    in_valid = 1'b1;
    in_data  = {32'hFF800000, 32'h7F800001,
                32'h7FC00000, 32'h7F800000};
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 ||
        out_class !== {6'h08, 6'h20, 6'h10, 6'h08}) begin
      errors++;
      $display("FAIL spc_class got %b/%h exp 1/%h", out_valid,
               out_class, {6'h08, 6'h20, 6'h10, 6'h08});
    end
    checks++;
    if (out_sign !== 4'b1000) begin
      errors++;
      $display("FAIL spc_sign got %b exp 1000", out_sign);
    end
    tick();
    checks++;
    if (nan_sticky !== 1'b1 || zero_cnt !== 16'd2) begin
      errors++;
      $display("FAIL spc_stats got %b/%0d exp 1/2",
               nan_sticky, zero_cnt);
    end
  endtask

  task automatic test_cnt_clr();
    in_valid = 1'b1;
    in_data  = {32'h3F800000, 32'h00000000,
                32'h80000000, 32'h00000000};
    tick();
    in_valid = 1'b0;
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (zero_cnt !== 16'd3) begin
      errors++;
      $display("FAIL clr_zero_cnt got %0d exp 3", zero_cnt);
    end
    checks++;
    if (nan_sticky !== 1'b0) begin
      errors++;
      $display("FAIL clr_nan got %b exp 0", nan_sticky);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] dat [6];
    logic [23:0]  ecl [6];
    logic [3:0]   esg [6];
    int sent;
    int rcv;
    int cyc;
    logic ivf;
    logic ovf;
    dat[0] = {32'h3F800000, 32'h3F800000,
              32'h3F800000, 32'h00000000};
    ecl[0] = {6'h04, 6'h04, 6'h04, 6'h01};
    esg[0] = 4'b0000;
    dat[1] = {4{32'h00000001}};
    ecl[1] = {4{6'h02}};
    esg[1] = 4'b0000;
    dat[2] = {4{32'h7F800000}};
    ecl[2] = {4{6'h08}};
    esg[2] = 4'b0000;
    dat[3] = {32'hBF800000, 32'h00000000,
              32'h00000000, 32'h80000000};
    ecl[3] = {6'h04, 6'h01, 6'h01, 6'h01};
    esg[3] = 4'b1001;
    dat[4] = {32'h7FC00000, 32'h3F800000,
              32'h00000001, 32'h00000000};
    ecl[4] = {6'h10, 6'h04, 6'h02, 6'h01};
    esg[4] = 4'b0000;
    dat[5] = {32'h7F800001, 32'hFFC00000,
              32'h80000001, 32'hC0000000};
    ecl[5] = {6'h20, 6'h10, 6'h02, 6'h04};
    esg[5] = 4'b0111;
    sent = 0;
    rcv  = 0;
    cyc  = 0;
    while (rcv < 6 && cyc < 40) begin
      in_valid  = (sent < 6);
      in_data   = (sent < 6) ? dat[sent] : 128'h0;
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      if (cyc == 3) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_in_ready_full got %b exp 0",
                   in_ready);
        end
      end
      if (out_valid === 1'b1 && rcv < 6) begin
        checks++;
        if (out_class !== ecl[rcv] || out_sign !== esg[rcv]) begin
          errors++;
          $display("FAIL b2b_beat%0d cyc%0d got %h/%b exp %h/%b",
                   rcv, cyc, out_class, out_sign,
                   ecl[rcv], esg[rcv]);
        end
      end
      ivf = in_valid && in_ready;
      ovf = out_valid && out_ready;
      if (ivf) sent++;
      if (ovf) rcv++;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (rcv != 6) begin
      errors++;
      $display("FAIL b2b_delivered got %0d exp 6", rcv);
    end
    checks++;
    if (zero_cnt !== 16'd8 || nan_sticky !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stats got %0d/%b exp 8/1",
               zero_cnt, nan_sticky);
    end
  endtask

  task automatic test_saturate();
    logic [3:0] exp_cnt [5];
    exp_cnt[0] = 4'd4;
    exp_cnt[1] = 4'd8;
    exp_cnt[2] = 4'd12;
    exp_cnt[3] = 4'd15;
    exp_cnt[4] = 4'd15;
    for (int k = 0; k < 5; k++) begin
      in_valid_4 = 1'b1;
      in_data_4  = 128'h0;
      tick();
      in_valid_4 = 1'b0;
      tick();
      tick();
      checks++;
      if (zero_cnt_4 !== exp_cnt[k]) begin
        errors++;
        $display("FAIL sat_beat%0d got %0d exp %0d",
                 k, zero_cnt_4, exp_cnt[k]);
      end
    end
  endtask

  task automatic test_rst_flight();
    int seen;
    in_valid = 1'b1;
    in_data  = {32'h7FC00000, 32'h00000000,
                32'h00000000, 32'h00000000};
    tick();
    in_data  = {32'h00000000, 32'h7F800001,
                32'h00000000, 32'h00000000};
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_hs got %b/%b exp 0/1",
               out_valid, in_ready);
    end
    checks++;
    if (zero_cnt !== 16'd0 || nan_sticky !== 1'b0) begin
      errors++;
      $display("FAIL rst_stats got %0d/%b exp 0/0",
               zero_cnt, nan_sticky);
    end
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_no_delivery got %0d exp 0", seen);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    cnt_clr     = 1'b0;
    in_valid_4  = 1'b0;
    in_data_4   = '0;
    out_ready_4 = 1'b1;
    cnt_clr_4   = 1'b0;
    test_reset();
    test_classes();
    test_special();
    test_cnt_clr();
    test_back_to_back();
    test_saturate();
    test_rst_flight();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
